// File: rtl/pmem_pkg.sv
// Shared types and constants for the cacheline physical-memory responder.
package pmem_pkg;

    localparam int LINE_W      = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, RECOVER} pmem_state_t;
    typedef enum logic {READ, WRITE} pmem_op_t;

endpackage

// File: rtl/pmem_line_ram.sv
// Single-port line store: synchronous write, registered read that holds until re.
module pmem_line_ram
    import pmem_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [INDEX_BITS-1:0] addr,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem [2**INDEX_BITS];

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency pmem target: serves one latched line request per LATENCY+2 cycles.
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int LATENCY    = 10,
    parameter int INDEX_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_resp,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              busy,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    pmem_state_t           state;
    pmem_op_t              op;
    logic [INDEX_BITS-1:0] idx;
    logic [LINE_W-1:0]     wdata_q;
    logic [7:0]            cnt;
    logic [31:0]           rd_cnt, wr_cnt;

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] ram_addr;
    logic                  ram_we, ram_re;
    logic                  unused_addr;

    assign req_idx     = pmem_address[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign unused_addr = ^{pmem_address[31:INDEX_BITS+OFFSET_BITS], pmem_address[OFFSET_BITS-1:0]};

    // The read register is loaded on the edge entering RESP, so with LATENCY==1
    // it must be addressed straight from the incoming request.
    assign ram_addr = (state == IDLE) ? req_idx : idx;
    assign ram_we   = rst_n && state == RESP && op == WRITE;
    assign ram_re   = rst_n && ((state == BUSY && cnt == 8'd0 && op == READ) ||
                                (LATENCY == 1 && state == IDLE && pmem_read && !pmem_write));

    assign rd_count = rd_cnt;
    assign wr_count = wr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= READ;
            idx       <= '0;
            cnt       <= '0;
            pmem_resp <= 1'b0;
            busy      <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                IDLE: if (pmem_write || pmem_read) begin
                    op   <= pmem_write ? WRITE : READ;
                    idx  <= req_idx;
                    busy <= 1'b1;
                    if (pmem_write) wdata_q <= pmem_wdata;
                    if (LATENCY == 1) begin
                        state     <= RESP;
                        pmem_resp <= 1'b1;
                    end else begin
                        state <= BUSY;
                        cnt   <= 8'(LATENCY - 2);
                    end
                end
                BUSY: if (cnt == 8'd0) begin
                    state     <= RESP;
                    pmem_resp <= 1'b1;
                end else begin
                    cnt <= cnt - 8'd1;
                end
                RESP: begin
                    state <= RECOVER;
                    if (op == READ && rd_cnt != '1)  rd_cnt <= rd_cnt + 32'd1;
                    if (op == WRITE && wr_cnt != '1) wr_cnt <= wr_cnt + 32'd1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    pmem_line_ram #(.INDEX_BITS(INDEX_BITS)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (pmem_rdata)
    );

`ifndef SYNTHESIS
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state == BUSY || state == RESP) |-> (pmem_read || pmem_write))
        else $error("pmem request dropped before pmem_resp");
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized bench for pmem_responder against a line-array/counter reference model.
module tb_pmem_responder;

    localparam int LAT = 10;

    logic         clk, rst_n;
    logic         pmem_read, pmem_write, pmem_resp, busy;
    logic [31:0]  pmem_address, rd_count, wr_count;
    logic [255:0] pmem_wdata, pmem_rdata;

    logic         rd1, wr1, resp1, busy1;
    logic [31:0]  addr1, rdc1, wrc1;
    logic [255:0] wdata1, rdata1;

    logic [255:0] mem_m [256];
    logic [255:0] last_rd;
    logic [31:0]  rc, wc;
    int           nchk, nerr;

    pmem_responder #(.LATENCY(LAT), .INDEX_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
        .pmem_rdata(pmem_rdata), .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
    );

    pmem_responder #(.LATENCY(1), .INDEX_BITS(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd1), .pmem_write(wr1),
        .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_resp(resp1),
        .pmem_rdata(rdata1), .busy(busy1), .rd_count(rdc1), .wr_count(wrc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // One full transaction: accept, LAT-cycle wait, resp pulse, RECOVER, back to IDLE.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] wd);
        int i;
        logic [255:0] exp_rd;
        i = int'((a >> 5) % 256);
        exp_rd = mem_m[i];
        pmem_read = rd; pmem_write = wr; pmem_address = a; pmem_wdata = wd;
        for (int c = 1; c <= LAT + 2; c++) begin
            @(posedge clk); #1;
            chk("resp", pmem_resp, c == LAT);
            chk("busy", busy, c <= LAT + 1);
            if (c == LAT && !wr) begin
                chk("rdata", pmem_rdata, exp_rd);
                last_rd = exp_rd;
            end
            if (c == LAT + 1) begin
                pmem_read = 0; pmem_write = 0;
                if (wr) begin
                    mem_m[i] = wd;
                    if (wc != '1) wc++;
                end else if (rc != '1) rc++;
                chk("rd_count", rd_count, rc);
                chk("wr_count", wr_count, wc);
                chk("rdata_hold", pmem_rdata, last_rd);
            end
        end
    endtask

    initial begin
        logic [255:0] v;
        int n;
        nchk = 0; nerr = 0; rc = 0; wc = 0; last_rd = '0;
        rst_n = 0; pmem_read = 0; pmem_write = 0; pmem_address = 0; pmem_wdata = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp", pmem_resp, 0);
        chk("rst_rdata", pmem_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_resp1", resp1, 0);
        for (int k = 0; k < 256; k++) begin
            v = rnd_line();
            dut.u_ram.mem[k] = v;
            mem_m[k] = v;
        end
        rst_n = 1;
        @(posedge clk); #1;

        // Directed: write then read of the same line via a different offset.
        do_op(0, 1, 32'h0000_0040, {32{8'hA5}});
        do_op(1, 0, 32'h0000_005F, '0);
        // Simultaneous read and write is served as a write.
        do_op(1, 1, 32'h0000_0060, 256'h1234);
        do_op(1, 0, 32'h0000_0060, '0);
        // Aliasing of upper address bits.
        do_op(1, 0, 32'h8000_0040, '0);

        // Held read: pulses every LAT+2 cycles, never adjacent.
        pmem_read = 1; pmem_address = 32'h0000_0120;
        n = 3 * LAT + 4;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            chk("held_resp", pmem_resp, (c >= LAT) && ((c - LAT) % (LAT + 2) == 0));
            if (pmem_resp) chk("held_rdata", pmem_rdata, mem_m[9]);
        end
        @(posedge clk); #1;
        chk("held_recover", pmem_resp, 0);
        pmem_read = 0;
        rc += 3; last_rd = mem_m[9];
        @(posedge clk); #1;
        chk("held_rd_count", rd_count, rc);

        // Random mix.
        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 3))
                0: do_op(1, 0, $urandom, '0);
                1: do_op(0, 1, $urandom, rnd_line());
                2: do_op(1, 1, $urandom, rnd_line());
                default: do_op(1, 0, 32'h0000_0040 | ($urandom & 32'hFFFF_E01F), '0);
            endcase
        end

        // Reset mid-flight: write to line 7 aborted in cycle 5.
        v = rnd_line();
        pmem_write = 1; pmem_address = 32'h0000_00E0; pmem_wdata = v;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            chk("abort_resp", pmem_resp, 0);
        end
        rst_n = 0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_resp2", pmem_resp, 0);
        chk("abort_wr_count", wr_count, 0);
        chk("abort_rd_count", rd_count, 0);
        chk("abort_rdata", pmem_rdata, 0);
        pmem_write = 0;
        @(posedge clk); #1;
        chk("abort_resp3", pmem_resp, 0);
        rst_n = 1; rc = 0; wc = 0; last_rd = '0;
        do_op(1, 0, 32'h0000_00E0, '0);

        // Saturation of the read counter.
        dut.rd_cnt = 32'hFFFF_FFFF;
        rc = 32'hFFFF_FFFF;
        do_op(1, 0, $urandom, '0);

        // LATENCY==1 instance: resp in cycle 1, then RECOVER.
        v = rnd_line();
        wr1 = 1; addr1 = 32'h0000_0120; wdata1 = v;
        @(posedge clk); #1;
        chk("l1_wr_resp", resp1, 1);
        @(posedge clk); #1;
        chk("l1_wr_recover", resp1, 0);
        chk("l1_wr_count", wrc1, 1);
        wr1 = 0;
        @(posedge clk); #1;
        rd1 = 1; addr1 = 32'hF000_0120;
        @(posedge clk); #1;
        chk("l1_rd_resp", resp1, 1);
        chk("l1_rdata", rdata1, v);
        @(posedge clk); #1;
        chk("l1_rd_recover", resp1, 0);
        chk("l1_rd_count", rdc1, 1);
        rd1 = 0;
        @(posedge clk); #1;
        chk("l1_idle", busy1, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Cycle-counted physical-memory responder that serves the target end of the cacheline pmem protocol driven by the cache arbiter: `pmem_read`/`pmem_write`, `pmem_address`, `pmem_wdata` in; `pmem_resp`, `pmem_rdata` out. It backs a bank of 256-bit lines with configurable fixed access latency and stands in for DRAM in simulation and FPGA builds. It also keeps saturating read/write access counters for performance runs.

## Interface
- `LATENCY`, 10: cycles from request acceptance to `pmem_resp`; legal range 1..255.
- `INDEX_BITS`, 8: line index width; the array holds 2^INDEX_BITS lines of 256 bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `pmem_read`  in  1  read request, held until `pmem_resp`.
- `pmem_write`  in  1  write request, held until `pmem_resp`.
- `pmem_address`  in  32  byte address; bits [4:0] are ignored.
- `pmem_wdata`  in  256  write line.
- `pmem_resp`  out  1  single-cycle completion pulse.
- `pmem_rdata`  out  256  read line, valid in the `pmem_resp` cycle.
- `busy`  out  1  high in every state except IDLE.
- `rd_count`  out  32  completed reads, saturating at 0xFFFFFFFF.
- `wr_count`  out  32  completed writes, saturating at 0xFFFFFFFF.

## Operation
- **States:** IDLE, BUSY, RESP, RECOVER.
- **IDLE:**
  - If `pmem_write`, latch op=WRITE, the index `pmem_address[INDEX_BITS+4:5]` and `pmem_wdata`.
  - Else if `pmem_read`, latch op=READ and the index.
  - `pmem_write` wins when both are high; the read is dropped, not queued.
  - On a latch, go to BUSY with the counter loaded to LATENCY-2. If LATENCY==1, go directly to RESP.
- **BUSY:**
  - Decrement the counter; at 0, go to RESP.
  - Input changes are ignored; only the latched request is served.
- **RESP:**
  - `pmem_resp`=1 for exactly this cycle.
  - READ: `pmem_rdata` shows the array line at the latched index.
  - WRITE: the latched wdata is committed to the array at the end of this cycle.
  - Increment the matching counter unless it is saturated.
  - Go to RECOVER.
- **RECOVER:**
  - One cycle, requests ignored, then go to IDLE.
  - This absorbs the arbiter's one-cycle return to its null state, so a still-held request is never served twice.
- **Address aliasing:** address bits above INDEX_BITS+4 are ignored.
- **Array contents:** not reset, X until first written. The bench preloads the array through a hierarchical reference or `$readmemh`.
- **Read-after-write:** a read that follows a completed write to the same index returns the new data.

## Timing
- **Latency:** request first high in cycle 0 (IDLE) -> `pmem_resp` high in cycle LATENCY. The next request can be accepted in cycle LATENCY+2 at the earliest.
- **Reset values:** `pmem_resp`=0, `pmem_rdata`=0, `busy`=0, `rd_count`=0, `wr_count`=0, state=IDLE.
- **`pmem_rdata`:** registered; it holds its last read value outside RESP and is unchanged by writes.
- **`rst_n` low mid-transaction:** abort next edge, no `pmem_resp`, no array write, counters cleared.
- **Request dropped before `pmem_resp`:** protocol violation; the responder still completes the latched op. This is flagged by a simulation-only assertion.

## Structure
- **`pmem_pkg`:**
  - `LINE_W`=256 and `OFFSET_BITS`=5.
  - `pmem_state_t` enum (IDLE, BUSY, RESP, RECOVER).
  - `pmem_op_t` enum (READ, WRITE).
- **Sub-module `pmem_line_ram`:**
  - Single-port 2^INDEX_BITS x 256 array.
  - Synchronous write enable.
  - Registered read port, addressed by the latched index.
- **Top level:** FSM, latency counter, request latches, counters.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles -> all outputs 0, `busy`=0.
- **Write then read:** LATENCY=10; write 0xA5..A5 at 0x0000_0040, hold until resp.
  - `pmem_resp` pulses exactly in cycle 10; `wr_count`=1.
  - A subsequent read of 0x0000_005F returns 0xA5..A5 in its resp cycle; `rd_count`=1.
- **Held request across the arbiter's gap:** keep `pmem_read` high continuously.
  - Responses come every LATENCY+2 cycles, each a single-cycle pulse.
  - No response is ever adjacent to another.
- **Simultaneous read and write:** `pmem_read`=`pmem_write`=1 at index 3 with wdata 0x1234.
  - Served as a write: `wr_count`=1, `rd_count`=0.
  - A later read of index 3 returns 0x1234.
- **Reset mid-flight:** drop `rst_n` in cycle 5 of a write.
  - No `pmem_resp`; the target line keeps its old value; state is IDLE.
  - LATENCY=1 variant: resp arrives in cycle 1.
- **Aliasing and saturation:**
  - Read of 0x8000_0040 returns the line at 0x0000_0040.
  - Force `rd_count` to 0xFFFFFFFF, complete one read -> `rd_count` stays 0xFFFFFFFF.
